// File: rtl/zbus_port_responder_if.sv
// ZX-bus I/O port signal bundle: host-driven address, data and strobes,
// plus the responder's data return path and port-claim indication.
interface zbus_port_responder_if;
    logic [15:0] za;
    logic [7:0]  zd_in;
    logic [7:0]  zd_out;
    logic        zd_oe;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        iorqge;

    // Host side: drives address, write data and strobes
    modport master (
        output za, zd_in, iorq_n, rd_n, wr_n, m1_n,
        input  zd_out, zd_oe, iorqge
    );

    // Responder side: claims the port and returns read data
    modport slave (
        input  za, zd_in, iorq_n, rd_n, wr_n, m1_n,
        output zd_out, zd_oe, iorqge
    );
endinterface

// File: rtl/zbus_port_responder.sv
// ZX-bus I/O port responder. Bus strobes are asynchronous to fclk and pass
// through 2-flop synchronizers. A matching IN cycle returns rdata (latched
// when the read is recognised); a matching OUT cycle pushes the written
// byte into a small write FIFO drained by an internal consumer.
module zbus_port_responder #(
    parameter logic [15:0] PORT  = 16'h00EF,
    parameter logic [15:0] MASK  = 16'h00FF,
    parameter int          DEPTH = 4
) (
    input  logic                 fclk,
    input  logic                 rst_n,
    zbus_port_responder_if.slave bus,
    output logic [7:0]           wq_data,
    output logic                 wq_valid,
    input  logic                 wq_ready,
    input  logic [7:0]           rdata,
    output logic                 rd_done,
    output logic                 ovf,
    input  logic                 ovf_clr
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              ONE      = 1;
    localparam logic [AW-1:0]   PTR_ONE  = ONE[AW-1:0];
    localparam logic [AW:0]     CNT_ONE  = ONE[AW:0];
    localparam logic [AW:0]     FULL_CNT = DEPTH[AW:0];

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        READ,
        WRITE,
        WAIT_END
    } state_t;

    // ------------------------------------------------------------------
    // Strobe synchronizers: bit 0 iorq_n, 1 rd_n, 2 wr_n, 3 m1_n
    // ------------------------------------------------------------------
    logic [3:0] strobe_raw;
    logic [3:0] strobe_sync;

    assign strobe_raw = {bus.m1_n, bus.wr_n, bus.rd_n, bus.iorq_n};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            // Two-flop synchronizer, idles at the inactive (high) level
            always_ff @(posedge fclk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg <= 1'b1;
                    s2_reg <= 1'b1;
                end else begin
                    s1_reg <= strobe_raw[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign strobe_sync[gi] = s2_reg;
        end
    endgenerate

    logic iorq_s;
    logic rd_s;
    logic wr_s;
    logic m1_s;

    assign iorq_s = strobe_sync[0];
    assign rd_s   = strobe_sync[1];
    assign wr_s   = strobe_sync[2];
    assign m1_s   = strobe_sync[3];

    // ------------------------------------------------------------------
    // Arming: the synchronizers come out of reset holding "idle", so the
    // first two samples are not real. Only after a genuine idle IORQ has
    // been seen may a new cycle be decoded; a cycle already running when
    // reset lifts is sent to WAIT_END instead.
    // ------------------------------------------------------------------
    logic [1:0] settle_reg;
    logic       armed_reg;

    // Count off the synchronizer fill, then arm on the first real idle IORQ
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            settle_reg <= 2'd0;
            armed_reg  <= 1'b0;
        end else begin
            if (settle_reg != 2'd2) begin
                settle_reg <= settle_reg + 2'd1;
            end
            if (settle_reg == 2'd2 && iorq_s) begin
                armed_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus-cycle FSM
    // ------------------------------------------------------------------
    state_t     state_reg;
    state_t     state_next;
    logic       iorqge_reg;
    logic       iorqge_next;
    logic       zd_oe_reg;
    logic       zd_oe_next;
    logic       rd_done_reg;
    logic       rd_done_next;
    logic [7:0] zd_out_reg;
    logic       load_rdata;
    logic       push;
    logic       addr_match;

    // Address is only looked at in DECODE, where IORQ is known to be active
    assign addr_match = ((bus.za & MASK) == (PORT & MASK));

    // State register
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and registered-output decisions
    always_comb begin
        state_next   = state_reg;
        iorqge_next  = iorqge_reg;
        zd_oe_next   = 1'b0;
        rd_done_next = 1'b0;
        load_rdata   = 1'b0;
        push         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!iorq_s) begin
                    // Interrupt acknowledge or an unarmed cycle: ignore it
                    if (armed_reg && m1_s) begin
                        state_next = DECODE;
                    end else begin
                        state_next = WAIT_END;
                    end
                end
            end
            DECODE: begin
                if (iorq_s) begin
                    state_next  = IDLE;
                    iorqge_next = 1'b0;
                end else if (addr_match) begin
                    iorqge_next = 1'b1;
                    if (!rd_s) begin
                        state_next = READ;
                        zd_oe_next = 1'b1;
                        load_rdata = 1'b1;
                    end else if (!wr_s) begin
                        state_next = WRITE;
                    end
                end else begin
                    state_next  = WAIT_END;
                    iorqge_next = 1'b0;
                end
            end
            READ: begin
                if (iorq_s) begin
                    state_next   = IDLE;
                    iorqge_next  = 1'b0;
                    rd_done_next = 1'b1;
                end else begin
                    zd_oe_next = 1'b1;
                end
            end
            WRITE: begin
                push       = 1'b1;
                state_next = WAIT_END;
            end
            WAIT_END: begin
                if (iorq_s) begin
                    state_next  = IDLE;
                    iorqge_next = 1'b0;
                end
            end
            default: begin
                state_next  = IDLE;
                iorqge_next = 1'b0;
            end
        endcase
    end

    // Bus-facing outputs, released asynchronously by reset
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            iorqge_reg  <= 1'b0;
            zd_oe_reg   <= 1'b0;
            rd_done_reg <= 1'b0;
            zd_out_reg  <= 8'h00;
        end else begin
            iorqge_reg  <= iorqge_next;
            zd_oe_reg   <= zd_oe_next;
            rd_done_reg <= rd_done_next;
            if (load_rdata) begin
                zd_out_reg <= rdata;
            end
        end
    end

    assign bus.iorqge = iorqge_reg;
    assign bus.zd_oe  = zd_oe_reg;
    assign bus.zd_out = zd_out_reg;
    assign rd_done    = rd_done_reg;

    // ------------------------------------------------------------------
    // Write FIFO with a registered head entry
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_inc;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic [7:0]    head_reg;
    logic [7:0]    head_next;
    logic          ovf_reg;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          ovf_set;

    assign wq_valid   = (count_reg != '0);
    assign pop        = wq_valid && wq_ready;
    assign full       = (count_reg == FULL_CNT);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok    = push && (!full || pop);
    assign ovf_set    = push && full && !pop;
    assign rd_ptr_inc = rd_ptr_reg + PTR_ONE;

    // Storage array, no reset on the data
    always_ff @(posedge fclk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= bus.zd_in;
        end
    end

    // Head and occupancy selection
    always_comb begin
        head_next  = head_reg;
        count_next = count_reg;
        if (pop) begin
            if (count_reg == CNT_ONE) begin
                // Byte arriving now becomes the head straight away
                if (push_ok) begin
                    head_next = bus.zd_in;
                end
            end else begin
                head_next = mem[rd_ptr_inc];
            end
        end else if (!wq_valid && push_ok) begin
            head_next = bus.zd_in;
        end
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Pointers, occupancy, head register and sticky overflow
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= 8'h00;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg <= count_next;
            head_reg  <= head_next;
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign wq_data = head_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_zbus_port_responder.sv
// Self-checking bench for zbus_port_responder. Written bytes are pushed to a
// scoreboard queue when the host write is issued and compared as the
// internal consumer pops them; bus responses are checked directly.
module tb_zbus_port_responder;
    localparam int DEPTH = 4;

    logic       fclk = 1'b0;
    logic       rst_n;
    logic [7:0] wq_data;
    logic       wq_valid;
    logic       wq_ready;
    logic [7:0] rdata;
    logic       rd_done;
    logic       ovf;
    logic       ovf_clr;

    zbus_port_responder_if bus();

    zbus_port_responder #(
        .PORT  (16'h00EF),
        .MASK  (16'h00FF),
        .DEPTH (DEPTH)
    ) dut (
        .fclk     (fclk),
        .rst_n    (rst_n),
        .bus      (bus),
        .wq_data  (wq_data),
        .wq_valid (wq_valid),
        .wq_ready (wq_ready),
        .rdata    (rdata),
        .rd_done  (rd_done),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 fclk = ~fclk;

    int         vec_cnt     = 0;
    int         miscmp_cnt  = 0;
    int         rd_done_cnt = 0;
    int         pop_cnt     = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge: counts rd_done pulses, scores FIFO pops
    always @(negedge fclk) begin : mon
        logic [7:0] e;
        if (rst_n) begin
            if (rd_done) begin
                rd_done_cnt++;
            end
            if (wq_valid && wq_ready) begin
                pop_cnt++;
                check("pop_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pop_data", 32'(wq_data), 32'(e));
                    $display("pop  data=%h expected=%h", wq_data, e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge fclk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus.iorq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.m1_n   = 1'b1;
    endtask

    task automatic model_push(input logic [7:0] d);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(d);
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    // Host IN cycle (or M1+IORQ interrupt acknowledge when m1n_v = 0)
    task automatic io_read(input logic [15:0] addr, input logic m1n_v, input logic respond,
                           input logic [7:0] data, input string tag);
        int rd0;
        rd0        = rd_done_cnt;
        rdata      = data;
        bus.za     = addr;
        bus.m1_n   = m1n_v;
        bus.iorq_n = 1'b0;
        bus.rd_n   = ~m1n_v;
        step(4);
        if (respond) check({tag, "_lat"}, 32'(bus.iorqge), 32'd1);
        step(6);
        check({tag, "_iorqge"}, 32'(bus.iorqge), 32'(respond));
        check({tag, "_oe"}, 32'(bus.zd_oe), 32'(respond));
        if (respond) begin
            rdata = ~data;
            step(1);
            check({tag, "_zd_out"}, 32'(bus.zd_out), 32'(data));
        end
        bus_idle();
        step(6);
        check({tag, "_rd_done"}, 32'(rd_done_cnt - rd0), 32'(respond));
        check({tag, "_oe_rel"}, 32'(bus.zd_oe), 32'd0);
        check({tag, "_iorqge_rel"}, 32'(bus.iorqge), 32'd0);
        if (!respond) check({tag, "_nopush"}, 32'(wq_valid), 32'(exp_q.size() != 0));
        $display("rd   %s addr=%h m1_n=%b zd_out=%h rd_done=%0d", tag, addr, m1n_v,
                 bus.zd_out, rd_done_cnt - rd0);
    endtask

    // Host OUT cycle; pop_mid pulses wq_ready in the push cycle
    task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input logic pop_mid);
        bus.za     = addr;
        bus.zd_in  = data;
        bus.m1_n   = 1'b1;
        bus.iorq_n = 1'b0;
        bus.wr_n   = 1'b0;
        step(4);
        check("wr_lat_iorqge", 32'(bus.iorqge), 32'd1);
        if (pop_mid) wq_ready = 1'b1;
        step(1);
        wq_ready = 1'b0;
        step(3);
        check("wr_oe", 32'(bus.zd_oe), 32'd0);
        bus_idle();
        step(4);
        model_push(data);
        check("wr_iorqge_rel", 32'(bus.iorqge), 32'd0);
        $display("wr   addr=%h data=%h pop_mid=%b model_depth=%0d", addr, data, pop_mid, exp_q.size());
    endtask

    task automatic drain(input string tag, input int exp_n);
        int p0;
        p0       = pop_cnt;
        wq_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && wq_valid; i++) step(1);
        wq_ready = 1'b0;
        step(1);
        check({tag, "_pops"}, 32'(pop_cnt - p0), 32'(exp_n));
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid"}, 32'(wq_valid), 32'd0);
        $display("drn  %s pops=%0d", tag, pop_cnt - p0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        wq_ready  = 1'b0;
        ovf_clr   = 1'b0;
        rdata     = 8'h00;
        bus.za    = 16'h0000;
        bus.zd_in = 8'h00;
        bus_idle();
        step(3);
        check("rst_zd_oe", 32'(bus.zd_oe), 32'd0);
        check("rst_zd_out", 32'(bus.zd_out), 32'd0);
        check("rst_iorqge", 32'(bus.iorqge), 32'd0);
        check("rst_rd_done", 32'(rd_done), 32'd0);
        check("rst_wq_valid", 32'(wq_valid), 32'd0);
        check("rst_wq_data", 32'(wq_data), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        step(5);

        // Host read of the port
        io_read(16'h12EF, 1'b1, 1'b1, 8'hA5, "read");

        // Single host write
        io_write(16'h00EF, 8'h3C, 1'b0);
        check("wr1_valid", 32'(wq_valid), 32'd1);
        check("wr1_data", 32'(wq_data), 32'h3C);
        drain("wr1", 1);

        // Overflow: five writes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) io_write(16'h00EF, 8'(i), 1'b0);
        check("ovf_set", 32'(ovf), 32'(exp_ovf));
        check("ovf_head", 32'(wq_data), 32'h01);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_clr", 32'(ovf), 32'(exp_ovf));
        drain("ovf", 4);

        // Non-matching port and interrupt acknowledge
        io_read(16'h00FE, 1'b1, 1'b0, 8'h99, "nomatch");
        io_read(16'h00EF, 1'b0, 1'b0, 8'h99, "intack");

        // Full FIFO with a pop in the push cycle
        io_write(16'h00EF, 8'h11, 1'b0);
        io_write(16'h00EF, 8'h22, 1'b0);
        io_write(16'h00EF, 8'h33, 1'b0);
        io_write(16'h00EF, 8'h44, 1'b0);
        check("full_ovf", 32'(ovf), 32'd0);
        io_write(16'h00EF, 8'h77, 1'b1);
        check("fullpop_ovf", 32'(ovf), 32'(exp_ovf));
        check("fullpop_head", 32'(wq_data), 32'h22);
        drain("fullpop", 4);

        // Reset in the middle of a read
        begin
            int rd0;
            rdata      = 8'hC3;
            bus.za     = 16'h12EF;
            bus.m1_n   = 1'b1;
            bus.iorq_n = 1'b0;
            bus.rd_n   = 1'b0;
            step(8);
            check("rstrd_pre_oe", 32'(bus.zd_oe), 32'd1);
            #3;
            rst_n = 1'b0;
            #1;
            check("rstrd_async_oe", 32'(bus.zd_oe), 32'd0);
            check("rstrd_async_iorqge", 32'(bus.iorqge), 32'd0);
            step(2);
            rst_n = 1'b1;
            rd0   = rd_done_cnt;
            step(10);
            check("rstrd_hold_iorqge", 32'(bus.iorqge), 32'd0);
            check("rstrd_hold_oe", 32'(bus.zd_oe), 32'd0);
            bus_idle();
            step(6);
            check("rstrd_rd_done", 32'(rd_done_cnt - rd0), 32'd0);
            $display("rst  during read, bus held low after release, iorqge=%b zd_oe=%b",
                     bus.iorqge, bus.zd_oe);
        end
        io_read(16'h12EF, 1'b1, 1'b1, 8'h5A, "rd_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end
endmodule
